// File: rtl/checkout_scan_sequencer_if.sv
// Scan-lane bus between the checkout front end and checkout_scan_sequencer.
// Discount tally signals exist only when DISCOUNT_TALLY_EN is defined.
interface checkout_scan_sequencer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          scan;
   logic [2:0]    upc_in;
   logic          mark_in;
   logic          clear;
   logic [2:0]    upc_out;
   logic          show;
   logic [CW-1:0] item_count;
   logic          full;
   logic          empty;
   logic          reject;
   logic          alarm;
`ifdef DISCOUNT_TALLY_EN
   logic [CW-1:0] discount_count;
   logic          discount_now;

   modport master (
      output scan, upc_in, mark_in, clear,
      input  upc_out, show, item_count, full, empty, reject, alarm,
      input  discount_count, discount_now
   );
   modport slave (
      input  scan, upc_in, mark_in, clear,
      output upc_out, show, item_count, full, empty, reject, alarm,
      output discount_count, discount_now
   );
`else
   modport master (
      output scan, upc_in, mark_in, clear,
      input  upc_out, show, item_count, full, empty, reject, alarm
   );
   modport slave (
      input  scan, upc_in, mark_in, clear,
      output upc_out, show, item_count, full, empty, reject, alarm
   );
`endif
endinterface

// File: rtl/checkout_scan_sequencer.sv
// Checkout-lane scan buffer with round-robin SHOW/GAP display of buffered UPC codes.
// Optional discount tally (discount_count, discount_now) enabled by DISCOUNT_TALLY_EN.
module checkout_scan_sequencer #(
   parameter int DEPTH = 4,
   parameter int DWELL = 25000000,
   parameter int GAP   = 5000000
) (
   input logic                      clk,
   input logic                      reset,
   checkout_scan_sequencer_if.slave io
);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int IW   = $clog2(DEPTH);
   localparam int TMAX = (DWELL > GAP) ? DWELL : GAP;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

   function automatic logic code_valid(input logic [2:0] c);
      return !(c == 3'b010 || c == 3'b111);
   endfunction

   function automatic logic code_stolen_risk(input logic [2:0] c);
      return (c == 3'b000 || c == 3'b100 || c == 3'b101);
   endfunction

   function automatic logic code_discount(input logic [2:0] c);
      return (c == 3'b011 || c == 3'b101 || c == 3'b110);
   endfunction

   state_t        state_q, state_d;
   logic [2:0]    slot_q [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] idx_q, idx_d, idx_nxt;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    upc_q, upc_d;
   logic          alarm_q, alarm_d;
   logic          reject_q, reject_d;
   logic          full_w, accept, refuse;

   always_comb begin
      full_w  = (count_q == CW'(DEPTH));
      accept  = io.scan & code_valid(io.upc_in) & ~full_w & ~io.clear;
      refuse  = io.scan & ~io.clear & (~code_valid(io.upc_in) | full_w);
      idx_nxt = ((CW'(idx_q) + CW'(1)) == count_q) ? '0 : idx_q + 1'b1;

      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      timer_d  = timer_q;
      upc_d    = upc_q;
      alarm_d  = alarm_q;
      reject_d = refuse;

      if (accept) begin
         count_d = count_q + 1'b1;
         if (!io.mark_in && code_stolen_risk(io.upc_in)) alarm_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // First accept bypasses the slot array so the item shows one cycle later
            if (count_q != '0 || accept) begin
               state_d = S_SHOW;
               idx_d   = '0;
               timer_d = '0;
               upc_d   = (count_q != '0) ? slot_q[0] : io.upc_in;
            end
         end
         S_SHOW: begin
            if (timer_q == TW'(DWELL - 1)) begin
               state_d = S_GAP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == TW'(GAP - 1)) begin
               state_d = S_SHOW;
               timer_d = '0;
               idx_d   = idx_nxt;
               upc_d   = slot_q[idx_nxt];
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (io.clear) begin
         state_d = S_IDLE;
         count_d = '0;
         idx_d   = '0;
         timer_d = '0;
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         upc_q    <= '0;
         alarm_q  <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         timer_q  <= timer_d;
         upc_q    <= upc_d;
         alarm_q  <= alarm_d;
         reject_q <= reject_d;
      end
   end

   // Slot storage carries no reset; contents are meaningless once count is zero
   always_ff @(posedge clk) begin
      if (accept) slot_q[count_q[IW-1:0]] <= io.upc_in;
   end

   assign io.upc_out    = upc_q;
   assign io.show       = (state_q == S_SHOW);
   assign io.item_count = count_q;
   assign io.full       = full_w;
   assign io.empty      = (count_q == '0);
   assign io.reject     = reject_q;
   assign io.alarm      = alarm_q;

`ifdef DISCOUNT_TALLY_EN
   logic [CW-1:0] disc_q, disc_d;

   always_comb begin
      disc_d = disc_q;
      if (accept && code_discount(io.upc_in)) disc_d = disc_q + 1'b1;
      if (io.clear) disc_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) disc_q <= '0;
      else       disc_q <= disc_d;
   end

   assign io.discount_count = disc_q;
   assign io.discount_now   = io.show & code_discount(upc_q);
`endif
endmodule

// File: tb/tb_checkout_scan_sequencer.sv
// Scoreboard bench for checkout_scan_sequencer: expected display rotation queued at scan time.
module tb_checkout_scan_sequencer;
   localparam int DEPTH = 4;
   localparam int DWELL = 4;
   localparam int GAP   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   checkout_scan_sequencer_if #(.DEPTH(DEPTH)) io ();

   checkout_scan_sequencer #(
      .DEPTH(DEPTH),
      .DWELL(DWELL),
      .GAP  (GAP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (io)
   );

   int         checks   = 0;
   int         failures = 0;
   logic [2:0] disp_q[$];
   bit         mon_en   = 1'b0;
   bit         disc_mon = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Display monitor: pops expected code on each show rise, checks dwell/gap lengths
   logic show_prev = 1'b0;
   int   hi_len = 0;
   int   lo_len = 0;
   bit   seen_fall = 1'b0;
   always @(negedge clk) begin
      if (!mon_en || reset) begin
         seen_fall = 1'b0;
         hi_len    = 0;
         lo_len    = 0;
      end else if (io.show && !show_prev) begin
         if (seen_fall) check_eq("gap_len", lo_len, GAP);
         if (disp_q.size() == 0) check_eq("disp_extra", disp_q.size(), 1);
         else check_eq("disp_code", io.upc_out, disp_q.pop_front());
         hi_len = 1;
      end else if (!io.show && show_prev) begin
         check_eq("dwell_len", hi_len, DWELL);
         seen_fall = 1'b1;
         lo_len    = 1;
      end else if (io.show) begin
         hi_len++;
      end else begin
         lo_len++;
      end
      show_prev = io.show;
   end

`ifdef DISCOUNT_TALLY_EN
   always @(negedge clk) begin
      if (disc_mon)
         check_eq("disc_now", io.discount_now,
                  io.show && (io.upc_out == 3'b011 || io.upc_out == 3'b101));
   end
`endif

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [2:0] code, input logic mark);
      io.scan    = 1'b1;
      io.upc_in  = code;
      io.mark_in = mark;
      @(negedge clk);
      io.scan    = 1'b0;
   endtask

   task automatic pulse_clear();
      io.clear = 1'b1;
      @(negedge clk);
      io.clear = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && disp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", disp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      io.scan    = 1'b0;
      io.upc_in  = 3'b000;
      io.mark_in = 1'b1;
      io.clear   = 1'b0;
      idle(3);
      reset = 1'b0;

      check_eq("rst_count", io.item_count, 0);
      check_eq("rst_empty", io.empty, 1);
      check_eq("rst_full", io.full, 0);
      check_eq("rst_show", io.show, 0);
      check_eq("rst_reject", io.reject, 0);
      check_eq("rst_alarm", io.alarm, 0);
      check_eq("rst_upc", io.upc_out, 0);

      // Single item cycles SHOW/GAP indefinitely
      mon_en = 1'b1;
      repeat (3) disp_q.push_back(3'b001);
      scan(3'b001, 1'b1);
      check_eq("t1_count", io.item_count, 1);
      check_eq("t1_empty", io.empty, 0);
      check_eq("t1_show", io.show, 1);
      check_eq("t1_upc", io.upc_out, 3'b001);
      wait_drain(60);
      mon_en = 1'b0;
      pulse_clear();
      check_eq("t1_clr_count", io.item_count, 0);
      check_eq("t1_clr_show", io.show, 0);
      idle(1);

      // Fill to DEPTH, refuse the fifth, rotation order
      mon_en = 1'b1;
      disp_q.push_back(3'b000);
      disp_q.push_back(3'b011);
      disp_q.push_back(3'b110);
      disp_q.push_back(3'b101);
      disp_q.push_back(3'b000);
      scan(3'b000, 1'b1); idle(1);
      scan(3'b011, 1'b1); idle(1);
      scan(3'b110, 1'b1); idle(1);
      scan(3'b101, 1'b1);
      check_eq("t2_full", io.full, 1);
      check_eq("t2_count4", io.item_count, 4);
      check_eq("t2_no_reject", io.reject, 0);
      idle(1);
      scan(3'b100, 1'b1);
      check_eq("t2_reject", io.reject, 1);
      check_eq("t2_count_hold", io.item_count, 4);
      idle(1);
      check_eq("t2_reject_pulse", io.reject, 0);
      check_eq("t2_alarm", io.alarm, 0);
      wait_drain(100);
      mon_en = 1'b0;
      pulse_clear();
      check_eq("t2_clr_full", io.full, 0);
      idle(1);

      // Invalid codes are refused and do not start the display
      mon_en = 1'b1;
      scan(3'b010, 1'b1);
      check_eq("t3_reject_010", io.reject, 1);
      check_eq("t3_count", io.item_count, 0);
      check_eq("t3_show", io.show, 0);
      idle(1);
      check_eq("t3_reject_end", io.reject, 0);
      scan(3'b111, 1'b1);
      check_eq("t3_reject_111", io.reject, 1);
      idle(1);
      check_eq("t3_show2", io.show, 0);
      check_eq("t3_empty", io.empty, 1);

      // Stolen item raises a sticky alarm; clear drops it
      disp_q.push_back(3'b100);
      scan(3'b100, 1'b0);
      check_eq("t4_alarm", io.alarm, 1);
      check_eq("t4_count", io.item_count, 1);
      idle(3);
      check_eq("t4_alarm_sticky", io.alarm, 1);
      mon_en = 1'b0;
      pulse_clear();
      check_eq("t4_clr_alarm", io.alarm, 0);
      check_eq("t4_clr_count", io.item_count, 0);
      check_eq("t4_clr_show", io.show, 0);
      check_eq("t4_clr_empty", io.empty, 1);
      idle(1);

      // Scan coincident with clear: clear wins, no reject
      scan(3'b001, 1'b1);
      scan(3'b011, 1'b1);
      scan(3'b110, 1'b1);
      check_eq("t5_count3", io.item_count, 3);
      io.clear = 1'b1;
      scan(3'b101, 1'b1);
      io.clear = 1'b0;
      check_eq("t5_count0", io.item_count, 0);
      check_eq("t5_no_reject", io.reject, 0);
      check_eq("t5_show", io.show, 0);
      idle(1);
      check_eq("t5_idle_show", io.show, 0);
      check_eq("t5_idle_reject", io.reject, 0);

      // Reset mid-operation restores reset values
      scan(3'b101, 1'b0);
      idle(2);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_eq("t6_count", io.item_count, 0);
      check_eq("t6_show", io.show, 0);
      check_eq("t6_alarm", io.alarm, 0);
      check_eq("t6_upc", io.upc_out, 0);
      idle(1);

`ifdef DISCOUNT_TALLY_EN
      disc_mon = 1'b1;
      scan(3'b011, 1'b1);
      scan(3'b101, 1'b1);
      scan(3'b001, 1'b1);
      check_eq("t7_disc_count", io.discount_count, 2);
      idle(30);
      pulse_clear();
      check_eq("t7_disc_clr", io.discount_count, 0);
      disc_mon = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
